// File: rtl/fadd_far_pipe_if.sv
// Handshake/data bundle for fadd_far_pipe.
//   master : producer of operands / consumer of results (upstream + downstream side)
//   slave  : the far-path adder itself
// Signals:
//   in_valid/in_ready   operand handshake
//   esmall_op/elarge_op smaller-/larger-exponent significands (explicit leading one)
//   exp_f, diff_abs     larger exponent, absolute exponent difference
//   sign_diff           1 = effective subtract
//   out_valid/out_ready result handshake
//   far_result, exp_far normalised, rounded significand and its exponent
//   inexact, exp_ovf, exp_unf  result flags
interface fadd_far_pipe_if #(
   parameter int FRAC_WIDTH = 36,
   parameter int EXP_WIDTH  = 8
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [FRAC_WIDTH-1:0] esmall_op;
   logic [FRAC_WIDTH-1:0] elarge_op;
   logic [EXP_WIDTH-1:0]  exp_f;
   logic [EXP_WIDTH:0]    diff_abs;
   logic                  sign_diff;
   logic                  out_valid;
   logic                  out_ready;
   logic [FRAC_WIDTH-1:0] far_result;
   logic [EXP_WIDTH-1:0]  exp_far;
   logic                  inexact;
   logic                  exp_ovf;
   logic                  exp_unf;

   modport master (
      output in_valid, esmall_op, elarge_op, exp_f, diff_abs, sign_diff, out_ready,
      input  in_ready, out_valid, far_result, exp_far, inexact, exp_ovf, exp_unf
   );

   modport slave (
      input  in_valid, esmall_op, elarge_op, exp_f, diff_abs, sign_diff, out_ready,
      output in_ready, out_valid, far_result, exp_far, inexact, exp_ovf, exp_unf
   );
endinterface

// File: rtl/fadd_far_pipe.sv
// Far-path significand adder, three register stages with valid/ready flow control.
//   p1: align smaller operand ({sig,G,R} >> diff_abs, sticky collects lost bits)
//   p2: add or subtract on FRAC_WIDTH+4 bits (sticky takes part in the borrow)
//   p3: one-position normalise, round-to-nearest-even, exponent saturation, flags
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       fadd_far_pipe_if.slave (operands in, result + flags out)
module fadd_far_pipe #(
   parameter int FRAC_WIDTH = 36,
   parameter int EXP_WIDTH  = 8,
   parameter int ROUND_EN   = 1
) (
   input logic            clk,
   input logic            rst,
   fadd_far_pipe_if.slave bus
);
   localparam int F = FRAC_WIDTH;
   localparam int E = EXP_WIDTH;
   localparam int W = FRAC_WIDTH + 4;
   localparam logic [E:0]   SHIFT_LIM = (E+1)'(F + 2);
   localparam logic [F+1:0] ONES      = '1;
   localparam logic [E:0]   EXP_ONE   = {{E{1'b0}}, 1'b1};

   // Round-to-nearest-even (or truncate); returns {carry_out, significand}.
   function automatic logic [F:0] round_rne(input logic [F-1:0] sig,
                                            input logic g, input logic r, input logic s);
      logic inc;
      inc = (ROUND_EN != 0) & g & (r | s | sig[0]);
      return {1'b0, sig} + {{F{1'b0}}, inc};
   endfunction

   // Exponent saturation; returns {overflow, exponent}. All-ones is reserved.
   function automatic logic [E:0] sat_exp(input logic [E:0] x);
      logic ovf;
      ovf = x[E] | (&x[E-1:0]);
      return {ovf, ovf ? {E{1'b1}} : x[E-1:0]};
   endfunction

   logic rdy1, rdy2, rdy3;

   logic             vld_p1_q, vld_p1_d;
   logic [F+2:0]     aln_p1_q, aln_p1_d;
   logic [F-1:0]     big_p1_q, big_p1_d;
   logic [E-1:0]     exp_p1_q, exp_p1_d;
   logic             sub_p1_q, sub_p1_d;

   logic             vld_p2_q, vld_p2_d;
   logic [W-1:0]     sum_p2_q, sum_p2_d;
   logic [E-1:0]     exp_p2_q, exp_p2_d;

   logic             vld_p3_q, vld_p3_d;
   logic [F-1:0]     res_p3_q, res_p3_d;
   logic [E-1:0]     xpf_p3_q, xpf_p3_d;
   logic             inx_p3_q, inx_p3_d;
   logic             ovf_p3_q, ovf_p3_d;
   logic             unf_p3_q, unf_p3_d;

   logic [F+1:0]     ext, shifted;
   logic             stk;
   logic [W-1:0]     opa, opb;
   logic [F-1:0]     nsig, rsig;
   logic             g, r, s, cy, unf;
   logic [E:0]       nexp, fexp, sexp;
   logic [F:0]       rnd;

   always_comb begin
      rdy3 = ~vld_p3_q | bus.out_ready;
      rdy2 = ~vld_p2_q | rdy3;
      rdy1 = ~vld_p1_q | rdy2;

      vld_p1_d = vld_p1_q; aln_p1_d = aln_p1_q; big_p1_d = big_p1_q;
      exp_p1_d = exp_p1_q; sub_p1_d = sub_p1_q;
      vld_p2_d = vld_p2_q; sum_p2_d = sum_p2_q; exp_p2_d = exp_p2_q;
      vld_p3_d = vld_p3_q; res_p3_d = res_p3_q; xpf_p3_d = xpf_p3_q;
      inx_p3_d = inx_p3_q; ovf_p3_d = ovf_p3_q; unf_p3_d = unf_p3_q;

      // ---- stage p1: alignment ----
      ext = {bus.esmall_op, 2'b00};
      if (bus.diff_abs >= SHIFT_LIM) begin
         shifted = '0;
         stk     = |bus.esmall_op;
      end else begin
         shifted = ext >> bus.diff_abs;
         stk     = |(ext & ~(ONES << bus.diff_abs));
      end
      if (rdy1) begin
         vld_p1_d = bus.in_valid;
         aln_p1_d = {shifted, stk};
         big_p1_d = bus.elarge_op;
         exp_p1_d = bus.exp_f;
         sub_p1_d = bus.sign_diff;
      end

      // ---- stage p2: add / subtract ----
      opa = {1'b0, big_p1_q, 3'b000};
      opb = {1'b0, aln_p1_q};
      if (rdy2) begin
         vld_p2_d = vld_p1_q;
         sum_p2_d = sub_p1_q ? (opa - opb) : (opa + opb);
         exp_p2_d = exp_p1_q;
      end

      // ---- stage p3: normalise, round, flag ----
      unf = 1'b0;
      if (sum_p2_q[W-1]) begin
         // carry out of the add: shift right, dropped bit joins the sticky
         nsig = sum_p2_q[W-1:4];
         g    = sum_p2_q[3];
         r    = sum_p2_q[2];
         s    = sum_p2_q[1] | sum_p2_q[0];
         nexp = {1'b0, exp_p2_q} + EXP_ONE;
      end else if (!sum_p2_q[W-2] && (exp_p2_q != '0)) begin
         nsig = sum_p2_q[W-3:2];
         g    = sum_p2_q[1];
         r    = sum_p2_q[0];
         s    = 1'b0;
         nexp = {1'b0, exp_p2_q} - EXP_ONE;
      end else begin
         // also the exponent-0 case: left shift suppressed, result stays unnormalised
         unf  = ~sum_p2_q[W-2];
         nsig = sum_p2_q[W-2:3];
         g    = sum_p2_q[2];
         r    = sum_p2_q[1];
         s    = sum_p2_q[0];
         nexp = {1'b0, exp_p2_q};
      end
      rnd  = round_rne(nsig, g, r, s);
      cy   = rnd[F];
      rsig = cy ? {1'b1, {(F-1){1'b0}}} : rnd[F-1:0];
      fexp = nexp + {{E{1'b0}}, cy};
      sexp = sat_exp(fexp);
      if (rdy3) begin
         vld_p3_d = vld_p2_q;
         res_p3_d = sexp[E] ? '0 : rsig;
         xpf_p3_d = sexp[E-1:0];
         inx_p3_d = g | r | s;
         ovf_p3_d = sexp[E];
         unf_p3_d = unf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0; aln_p1_q <= '0; big_p1_q <= '0; exp_p1_q <= '0; sub_p1_q <= 1'b0;
         vld_p2_q <= 1'b0; sum_p2_q <= '0; exp_p2_q <= '0;
         vld_p3_q <= 1'b0; res_p3_q <= '0; xpf_p3_q <= '0;
         inx_p3_q <= 1'b0; ovf_p3_q <= 1'b0; unf_p3_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d; aln_p1_q <= aln_p1_d; big_p1_q <= big_p1_d;
         exp_p1_q <= exp_p1_d; sub_p1_q <= sub_p1_d;
         vld_p2_q <= vld_p2_d; sum_p2_q <= sum_p2_d; exp_p2_q <= exp_p2_d;
         vld_p3_q <= vld_p3_d; res_p3_q <= res_p3_d; xpf_p3_q <= xpf_p3_d;
         inx_p3_q <= inx_p3_d; ovf_p3_q <= ovf_p3_d; unf_p3_q <= unf_p3_d;
      end
   end

   assign bus.in_ready   = rdy1;
   assign bus.out_valid  = vld_p3_q;
   assign bus.far_result = res_p3_q;
   assign bus.exp_far    = xpf_p3_q;
   assign bus.inexact    = inx_p3_q;
   assign bus.exp_ovf    = ovf_p3_q;
   assign bus.exp_unf    = unf_p3_q;
endmodule

// File: tb/tb_fadd_far_pipe.sv
// Scoreboard bench for fadd_far_pipe (FRAC_WIDTH=36, EXP_WIDTH=8, ROUND_EN=1).
module tb_fadd_far_pipe;
   typedef struct {
      logic [35:0] res;
      logic [7:0]  ex;
      logic        inx;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   exp_t sb[$];

   fadd_far_pipe_if #(.FRAC_WIDTH(36), .EXP_WIDTH(8)) bus ();

   fadd_far_pipe #(.FRAC_WIDTH(36), .EXP_WIDTH(8), .ROUND_EN(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference: align with explicit sticky loop, add on 40 bits, normalise, RNE.
   function automatic exp_t model(input logic [35:0] el, input logic [35:0] es,
                                  input logic [7:0] ef, input logic [8:0] d, input logic sub);
      logic [37:0] ext, sh;
      logic        stk, gg, rr, ss, inc;
      logic [39:0] a, b, sm;
      logic [35:0] m;
      logic [36:0] rd;
      int          e;
      exp_t        o;
      ext = {es, 2'b00};
      stk = 1'b0;
      if (d >= 9'd38) begin
         sh  = '0;
         stk = |es;
      end else begin
         sh = ext >> d;
         for (int i = 0; i < 38; i++) if (i < int'(d)) stk = stk | ext[i];
      end
      a  = {1'b0, el, 3'b000};
      b  = {1'b0, sh, stk};
      sm = sub ? a - b : a + b;
      e  = int'(ef);
      o.unf = 1'b0;
      if (sm[39]) begin
         m = sm[39:4]; gg = sm[3]; rr = sm[2]; ss = sm[1] | sm[0]; e = e + 1;
      end else if (!sm[38]) begin
         if (ef == 8'd0) begin
            o.unf = 1'b1;
            {m, gg, rr, ss} = sm[38:0];
         end else begin
            {m, gg, rr} = sm[37:0]; ss = 1'b0; e = e - 1;
         end
      end else begin
         {m, gg, rr, ss} = sm[38:0];
      end
      o.inx = gg | rr | ss;
      inc   = gg & (rr | ss | m[0]);
      rd    = {1'b0, m} + {36'd0, inc};
      if (rd[36]) begin
         m = 36'h800000000; e = e + 1;
      end else begin
         m = rd[35:0];
      end
      if (e >= 255) begin
         o.ovf = 1'b1; o.ex = 8'hFF; o.res = '0;
      end else begin
         o.ovf = 1'b0; o.ex = e[7:0]; o.res = m;
      end
      return o;
   endfunction

   function automatic exp_t mk(input logic [35:0] res, input logic [7:0] ex,
                               input logic inx, input logic ovf, input logic unf);
      exp_t o;
      o.res = res; o.ex = ex; o.inx = inx; o.ovf = ovf; o.unf = unf;
      return o;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [35:0] el, input logic [35:0] es, input logic [7:0] ef,
                       input logic [8:0] d, input logic sub, input exp_t want);
      int   t;
      logic acc;
      t = 0;
      acc = 1'b0;
      bus.in_valid  = 1'b1;
      bus.elarge_op = el;
      bus.esmall_op = es;
      bus.exp_f     = ef;
      bus.diff_abs  = d;
      bus.sign_diff = sub;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (acc) sb.push_back(want);
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) check_val("in_timeout", 64'(acc), 64'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check_val("drain", 64'(sb.size()), 64'(0));
   endtask

   // Output monitor: compare against the queue head, pop only on a transfer.
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         check_val("sb_nonempty", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            check_val(bus.out_ready ? "res" : "stall_res", 64'(bus.far_result), 64'(sb[0].res));
            check_val(bus.out_ready ? "exp" : "stall_exp", 64'(bus.exp_far), 64'(sb[0].ex));
            check_val("inexact", 64'(bus.inexact), 64'(sb[0].inx));
            check_val("exp_ovf", 64'(bus.exp_ovf), 64'(sb[0].ovf));
            check_val("exp_unf", 64'(bus.exp_unf), 64'(sb[0].unf));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [63:0] r64;
      logic [35:0] el, es;
      logic [7:0]  ef;
      logic [8:0]  d;
      logic        sub;
      int          t0, w;

      bus.in_valid = 1'b0; bus.elarge_op = '0; bus.esmall_op = '0; bus.exp_f = '0;
      bus.diff_abs = '0; bus.sign_diff = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check_val("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check_val("rst_result", 64'(bus.far_result), 64'(0));
      check_val("rst_exp", 64'(bus.exp_far), 64'(0));
      check_val("rst_flags", 64'({bus.inexact, bus.exp_ovf, bus.exp_unf}), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases, expectations worked by hand.
      send(36'h800000000, 36'h800000000, 8'h80, 9'd0,  1'b0, mk(36'h800000000, 8'h81, 0, 0, 0));
      send(36'h800000000, 36'h800000000, 8'h80, 9'd1,  1'b1, mk(36'h800000000, 8'h7F, 0, 0, 0));
      send(36'hFFFFFFFFF, 36'h800000000, 8'h10, 9'd36, 1'b0, mk(36'h800000000, 8'h11, 1, 0, 0));
      send(36'h800000000, 36'h800000000, 8'h10, 9'd36, 1'b0, mk(36'h800000000, 8'h10, 1, 0, 0));
      send(36'h800000000, 36'h800000000, 8'hFE, 9'd0,  1'b0, mk(36'h000000000, 8'hFF, 0, 1, 0));
      send(36'h800000000, 36'h800000000, 8'h00, 9'd1,  1'b1, mk(36'h400000000, 8'h00, 0, 0, 1));
      send(36'h800000000, 36'h800000001, 8'h20, 9'd40, 1'b1, mk(36'h800000000, 8'h20, 1, 0, 0));
      drain();

      // Random back-to-back burst at full throughput.
      t0 = cyc;
      for (int i = 0; i < 40; i++) begin
         r64 = {$urandom, $urandom};
         el  = {1'b1, r64[34:0]};
         r64 = {$urandom, $urandom};
         es  = {1'b1, r64[34:0]};
         sub = 1'(($urandom >> 3) & 1);
         d   = sub ? 9'($urandom_range(2, 45)) : 9'($urandom_range(0, 45));
         ef  = 8'($urandom_range(0, 255));
         send(el, es, ef, d, sub, model(el, es, ef, d, sub));
      end
      check_val("throughput", 64'(cyc - t0), 64'(40));
      drain();

      // Backpressure: 6 ops, out_ready low for 5 cycles after the first result.
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               el = 36'h900000000 + 36'(i * 36'h01234567);
               es = 36'hC00000000 - 36'(i * 36'h00765432);
               send(el, es, 8'(8'h40 + i), 9'(3 + i), 1'(i & 1),
                    model(el, es, 8'(8'h40 + i), 9'(3 + i), 1'(i & 1)));
            end
         end
         begin
            w = 0;
            while (!bus.out_valid && w < 50) begin
               @(negedge clk);
               w++;
            end
            check_val("stall_start", 64'(w < 50), 64'(1));
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            @(negedge clk);
            check_val("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check_val("stall_out_valid", 64'(bus.out_valid), 64'(1));
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset mid-stream.
      send(36'h800000000, 36'h800000000, 8'h50, 9'd0, 1'b0, mk(36'h800000000, 8'h51, 0, 0, 0));
      send(36'h800000000, 36'h800000000, 8'h50, 9'd1, 1'b1, mk(36'h800000000, 8'h4F, 0, 0, 0));
      send(36'h800000000, 36'h800000000, 8'h60, 9'd0, 1'b0, mk(36'h800000000, 8'h61, 0, 0, 0));
      rst = 1'b1;
      #1;
      check_val("rst_mid_valid", 64'(bus.out_valid), 64'(0));
      check_val("rst_mid_ready", 64'(bus.in_ready), 64'(1));
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("no_stale", 64'(bus.out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      send(36'hFFFFFFFFF, 36'h800000000, 8'h10, 9'd36, 1'b0, mk(36'h800000000, 8'h11, 1, 0, 0));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fadd_far_pipe.md
Name: fadd_far_pipe

Overview:
- Pipelined, parametrised successor to the combinational far-path adder in the FADD datapath.
- Aligns the smaller-exponent operand, adds or subtracts it, normalises by at most one position, and rounds to nearest-even with guard/round/sticky bits.
- Three register stages with valid/ready flow control. Sits between the exponent-compare/swap stage and the far/near result mux.

Parameters:
- FRAC_WIDTH, 36: significand width including the explicit leading one (MSB).
- EXP_WIDTH, 8: exponent width.
- ROUND_EN, 1: 1 = round-to-nearest-even; 0 = truncate. Flags are still computed when ROUND_EN = 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand set is valid.
- in_ready  out  1  block accepts the input this cycle.
- esmall_op  in  FRAC_WIDTH  significand of the smaller-exponent operand.
- elarge_op  in  FRAC_WIDTH  significand of the larger-exponent operand.
- exp_f  in  EXP_WIDTH  larger exponent.
- diff_abs  in  EXP_WIDTH+1  absolute exponent difference.
- sign_diff  in  1  1 = effective subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- far_result  out  FRAC_WIDTH  normalised, rounded significand.
- exp_far  out  EXP_WIDTH  result exponent.
- inexact  out  1  any of G, R or S was nonzero after normalisation.
- exp_ovf  out  1  result exponent overflowed.
- exp_unf  out  1  normalisation left shift was blocked at exponent 0.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - All stage valids, all data registers and all outputs clear to 0.
  - in_ready is 1 after reset.
  - Reset asserted mid-operation discards in-flight operations. No output pulse follows deassertion.
- Handshake:
  - Transfer occurs on valid & ready.
  - Stage k advances when its successor is empty or advancing: rdy3 = ~v3 | out_ready; rdy2 = ~v2 | rdy3; rdy1 = ~v1 | rdy2; in_ready = rdy1.
  - in_ready is combinational from out_ready.
  - Full throughput is one operation per cycle.
  - Latency is 3 cycles from the input handshake to out_valid when unstalled.
  - Outputs hold stable while out_valid & ~out_ready. Order is preserved and nothing is dropped.
- S1, align:
  - Form {esmall_op, G, R} and shift right by diff_abs.
  - S = OR of all bits shifted below R.
  - When diff_abs >= FRAC_WIDTH+2: shifted significand, G and R are 0, and S = |esmall_op.
  - Register the aligned operand, elarge_op, exp_f and sign_diff.
- S2, add:
  - Operands are FRAC_WIDTH+4 bits: {0, elarge_op, 000} and {0, aligned, G, R, S}.
  - Compute the sum, or the difference when sign_diff = 1. Two's-complement subtract; the sticky participates in the borrow.
- S3, normalise, round and flag:
  - Top bit set: shift right 1 (the shifted-out bit ORs into S), exp+1.
  - Else significand MSB clear: shift left 1, exp-1. The far path needs at most one position.
  - Else: no shift, exponent unchanged.
  - RNE (ROUND_EN = 1): increment when G & (R | S | LSB).
  - Rounding carry-out: far_result = 1 followed by zeros, exp+1.
  - inexact = G | R | S after normalisation.
- Exponent boundaries:
  - exp_ovf: final exponent carries past 2^EXP_WIDTH-1 or equals all-ones. exp_far is then forced to all-ones and far_result to 0.
  - exp_unf: exp_f = 0 and a left shift is required. The shift is suppressed, exp_far = 0, and the significand passes unnormalised.
  - exp_ovf and exp_unf are mutually exclusive.
- Simultaneous events: input accept and output drain in the same cycle are both legal. A full pipeline with out_ready = 1 keeps in_ready = 1.

Test Plan (FRAC_WIDTH=36, EXP_WIDTH=8, ROUND_EN=1):
- Right-shift normalise: elarge = esmall = 36'h800000000, diff_abs = 0, sign_diff = 0, exp_f = 8'h80 -> 3 cycles later far_result = 36'h800000000, exp_far = 8'h81, inexact = 0.
- Left-shift normalise: same operands, diff_abs = 1, sign_diff = 1, exp_f = 8'h80 -> far_result = 36'h800000000, exp_far = 8'h7F, flags 0.
- Round carry-out: elarge = 36'hFFFFFFFFF, esmall = 36'h800000000, diff_abs = 36, add, exp_f = 8'h10 -> G = 1, round up with carry, far_result = 36'h800000000, exp_far = 8'h11, inexact = 1.
- Tie-to-even: elarge = 36'h800000000, esmall = 36'h800000000, diff_abs = 36, add -> no increment, far_result = 36'h800000000, exp_far = exp_f, inexact = 1.
- Exponent boundaries:
  - exp_f = 8'hFE with the right-shift case -> exp_ovf = 1, exp_far = 8'hFF, far_result = 0.
  - exp_f = 0 with the left-shift case -> exp_unf = 1, exp_far = 0.
- Backpressure and reset:
  - 6 back-to-back ops, out_ready low for 5 cycles after the first out_valid -> in_ready falls with 3 stages full. All 6 results arrive in order with none lost; outputs stay stable while stalled.
  - rst asserted mid-stream -> out_valid = 0 immediately and no stale results appear after release.
